// File: rtl/spawn_sched_pkg.sv
// Shared types and constants for the obstacle spawn scheduler.
// Holds the FSM state encoding, LFSR taps/seed and the difficulty-ramp constants.
package spawn_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_PICK,
      ST_FIRE
   } sched_state_t;

   localparam logic [15:0] LFSR_TAPS     = 16'hB400;
   localparam logic [15:0] DEF_SEED      = 16'hACE1;
   localparam logic [15:0] RAMP_INTERVAL = 16'd16;
   localparam logic [15:0] RAMP_FLOOR    = 16'd2;

   function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
      return cur[0] ? ({1'b0, cur[15:1]} ^ LFSR_TAPS) : {1'b0, cur[15:1]};
   endfunction

   // Shrinks the minimum gap by one whenever the new spawn count lands on a ramp boundary.
   function automatic logic [15:0] ramp_next(input logic [15:0] cur_gap,
                                             input logic [15:0] new_count);
      if (((new_count % RAMP_INTERVAL) == 16'd0) && (cur_gap > RAMP_FLOOR)) begin
         return cur_gap - 16'd1;
      end
      return cur_gap;
   endfunction

endpackage

// File: rtl/spawn_lfsr.sv
// 16-bit Galois LFSR, free-running every clock out of reset; a zero SEED is replaced by 1
// so the register can never lock up at zero.
module spawn_lfsr
   import spawn_sched_pkg::*;
#(
   parameter logic [15:0] SEED = DEF_SEED
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] lfsr_o
);

   localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? 16'h0001 : SEED;

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   assign lfsr_d = lfsr_step(lfsr_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= SEED_SAFE;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign lfsr_o = lfsr_q;

endmodule

// File: rtl/spawn_scheduler.sv
// Obstacle spawn scheduler: frame-counted gap with LFSR extension, random-start lane search, one-hot spawn pulse.
// Define SPAWN_SCHEDULER_RAMP_EN to compile in the difficulty ramp that shrinks the base gap every 16 spawns.
module spawn_scheduler
   import spawn_sched_pkg::*;
#(
   parameter int          LANES   = 3,
   parameter int          MIN_GAP = 8,
   parameter int          RAND_W  = 4,
   parameter logic [15:0] SEED    = DEF_SEED,
   localparam int         SEL_W   = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_tick,
   input  logic             run,
   input  logic [LANES-1:0] lane_active,
   output logic [LANES-1:0] spawn_en,
   output logic [SEL_W-1:0] lane_sel,
   output logic [15:0]      spawn_count
);

   logic [15:0]        lfsr;
   sched_state_t       state_q;
   logic [15:0]        gap_q;
   logic [15:0]        spawn_cnt_q;
   logic [15:0]        spawn_cnt_d;
   logic [LANES-1:0]   spawn_en_q;
   logic [LANES-1:0]   recent_q;
   logic [SEL_W-1:0]   lane_sel_q;
   logic [15:0]        gap_base;
   logic [15:0]        gap_load;
   logic [LANES-1:0]   busy;
   logic [7:0]         start_lane;
   logic [2*LANES-1:0] busy_rot;
   logic [3:0]         lane_sum;
   logic [SEL_W-1:0]   lane_pick;
   logic [LANES-1:0]   pick_onehot;
   logic               lane_found;
   logic               fire_go;
   logic               unused_bits;

   spawn_lfsr #(.SEED(SEED)) u_lfsr (
      .clk    (clk),
      .rst_n  (rst_n),
      .lfsr_o (lfsr)
   );

`ifdef SPAWN_SCHEDULER_RAMP_EN
   logic [15:0] min_gap_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_gap_q <= 16'(MIN_GAP);
      end else if (fire_go && (spawn_cnt_q != 16'hFFFF)) begin
         min_gap_q <= ramp_next(min_gap_q, spawn_cnt_d);
      end
   end

   assign gap_base = min_gap_q;
`else
   assign gap_base = 16'(MIN_GAP);
`endif

   assign gap_load = gap_base + 16'(lfsr[RAND_W-1:0]);

   // Rotate the doubled busy vector so bit 0 is the start lane; the first clear bit is the winner.
   always_comb begin
      busy       = lane_active | recent_q;
      start_lane = lfsr[7:0] % 8'(LANES);
      busy_rot   = {busy, busy} >> start_lane;
      lane_found = 1'b0;
      lane_sum   = 4'd0;
      for (int p = 0; p < LANES; p++) begin
         if (!lane_found && !busy_rot[p]) begin
            lane_found = 1'b1;
            lane_sum   = 4'(start_lane) + 4'(p);
         end
      end
      if (lane_sum >= 4'(LANES)) begin
         lane_sum = lane_sum - 4'(LANES);
      end
      lane_pick   = SEL_W'(lane_sum);
      pick_onehot = LANES'(1) << lane_pick;
   end

   assign fire_go     = run && (state_q == ST_PICK) && lane_found;
   assign spawn_cnt_d = !fire_go ? spawn_cnt_q :
                        (spawn_cnt_q == 16'hFFFF) ? spawn_cnt_q : spawn_cnt_q + 16'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         gap_q       <= 16'd0;
         spawn_en_q  <= '0;
         recent_q    <= '0;
         lane_sel_q  <= '0;
         spawn_cnt_q <= 16'd0;
      end else begin
         spawn_en_q  <= '0;
         recent_q    <= '0;
         spawn_cnt_q <= spawn_cnt_d;
         if (!run) begin
            state_q <= ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  gap_q   <= gap_load;
                  state_q <= ST_WAIT;
               end
               ST_WAIT: begin
                  if (frame_tick) begin
                     if (gap_q <= 16'd1) begin
                        state_q <= ST_PICK;
                     end else begin
                        gap_q <= gap_q - 16'd1;
                     end
                  end
               end
               ST_PICK: begin
                  if (lane_found) begin
                     state_q    <= ST_FIRE;
                     lane_sel_q <= lane_pick;
                     spawn_en_q <= pick_onehot;
                     // Blocks the chosen lane until its animator's active flag catches up.
                     recent_q   <= pick_onehot;
                  end else begin
                     gap_q   <= 16'd1;
                     state_q <= ST_WAIT;
                  end
               end
               ST_FIRE: begin
                  gap_q   <= gap_load;
                  state_q <= ST_WAIT;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign unused_bits = ^{lfsr[15:8], busy_rot[2*LANES-1:LANES]};

   assign spawn_en    = spawn_en_q;
   assign lane_sel    = lane_sel_q;
   assign spawn_count = spawn_cnt_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Scoreboard bench for spawn_scheduler: the driver predicts each spawn (cycle, lane, count) into a queue,
// a negedge monitor pops and compares whenever spawn_en is seen.
module tb_spawn_scheduler;
   import spawn_sched_pkg::*;

   localparam int          LANES   = 3;
   localparam int          MIN_GAP = 8;
   localparam int          RAND_W  = 4;
   localparam logic [15:0] SEED    = 16'hACE0;
   localparam int          K_NORM  = 0;
   localparam int          K_KILL  = 1;
   localparam int          K_RST   = 2;

   typedef struct {
      int          cyc;
      logic [2:0]  en;
      logic [1:0]  sel;
      logic [15:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_tick = 1'b0;
   logic        run = 1'b0;
   logic [2:0]  lane_active = 3'b000;
   logic [2:0]  spawn_en;
   logic [1:0]  lane_sel;
   logic [15:0] spawn_count;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          gap = 0;
   logic [15:0] exp_count = 16'd0;
   logic [15:0] m;
   bit          fired;
   exp_t        q[$];

   spawn_scheduler #(
      .LANES   (LANES),
      .MIN_GAP (MIN_GAP),
      .RAND_W  (RAND_W),
      .SEED    (SEED)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_tick  (frame_tick),
      .run         (run),
      .lane_active (lane_active),
      .spawn_en    (spawn_en),
      .lane_sel    (lane_sel),
      .spawn_count (spawn_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] lfsr_ref(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= SEED;
      else        m <= lfsr_ref(m);
   end

   function automatic logic [2:0] busy_pattern(input int pat, input int st);
      case (pat)
         1:       return 3'((1 << st) | (1 << ((st + 1) % 3)));
         2:       return 3'b111;
         3:       return 3'(1 << st);
         default: return 3'b000;
      endcase
   endfunction

   function automatic int pick_lane(input int st, input logic [2:0] b);
      for (int i = 0; i < 3; i++) begin
         if (!b[2'((st + i) % 3)]) return (st + i) % 3;
      end
      return -1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (spawn_en != 3'b000) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_spawn en=%b cycle %0d", spawn_en, cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               if (e.cyc != cyc || spawn_en !== e.en || lane_sel !== e.sel || spawn_count !== e.cnt) begin
                  errors++;
                  $display("FAIL spawn got cyc=%0d en=%b sel=%0d cnt=%0h want cyc=%0d en=%b sel=%0d cnt=%0h",
                           cyc, spawn_en, lane_sel, spawn_count, e.cyc, e.en, e.sel, e.cnt);
               end
            end
         end else if (q.size() != 0 && q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_spawn want cyc=%0d en=%b now cycle %0d", q[0].cyc, q[0].en, cyc);
            void'(q.pop_front());
         end
      end
   end

   // One frame tick; on the tick that expires the gap, apply the lane pattern and predict the outcome.
   task automatic frame(input int pat, input int kind);
      logic [15:0] pm;
      int          st;
      int          ln;
      bit          expiring;
      exp_t        e;
      expiring = (gap == 1);
      pm = lfsr_ref(m);
      st = int'(pm[7:0]) % LANES;
      if (expiring) lane_active = busy_pattern(pat, st);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      if (!expiring) begin
         gap--;
      end else if (kind == K_KILL) begin
         run = 1'b0;
         @(negedge clk);
         chk("kill_no_pulse", 32'(spawn_en), 32'd0);
         chk("kill_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
         chk("kill_count_hold", 32'(spawn_count), 32'(exp_count));
         return;
      end else begin
         ln = pick_lane(st, lane_active);
         if (ln < 0) begin
            gap = 1;
            @(negedge clk);
            chk("all_busy_no_pulse", 32'(spawn_en), 32'd0);
         end else begin
            if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
            e.cyc = cyc + 1;
            e.en  = 3'(1 << ln);
            e.sel = 2'(ln);
            e.cnt = exp_count;
            q.push_back(e);
            fired = 1'b1;
            @(negedge clk);
            gap = MIN_GAP + int'(m[RAND_W-1:0]);
            if (kind == K_RST) begin
               #2 rst_n = 1'b0;
               #1;
               chk("rst_spawn_en_drop", 32'(spawn_en), 32'd0);
               chk("rst_count_zero", 32'(spawn_count), 32'd0);
               exp_count = 16'd0;
               return;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic spawn_one(input int pat);
      int n = 0;
      fired = 1'b0;
      while (!fired && n < 40) begin
         frame(pat, K_NORM);
         n++;
      end
      checks++;
      if (!fired) begin
         errors++;
         $display("FAIL spawn_timeout got no expiry after %0d frames", n);
      end
   endtask

   task automatic start_run();
      run = 1'b1;
      gap = MIN_GAP + int'(m[RAND_W-1:0]);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_spawn_en", 32'(spawn_en), 32'd0);
      chk("reset_lane_sel", 32'(lane_sel), 32'd0);
      chk("reset_count", 32'(spawn_count), 32'd0);
      chk("reset_lfsr", 32'(dut.lfsr), 32'(SEED));

      // SEED low nibble is 0, so the first gap is exactly MIN_GAP.
      rst_n = 1'b1;
      run   = 1'b1;
      gap   = 8;
      @(negedge clk);
      spawn_one(0);
      spawn_one(1);
      spawn_one(3);

      while (gap > 1) frame(2, K_NORM);
      frame(2, K_NORM);
      spawn_one(0);

      repeat (3) frame(0, K_NORM);
      run = 1'b0;
      repeat (6) begin
         frame_tick = 1'b1;
         @(negedge clk);
         frame_tick = 1'b0;
         @(negedge clk);
      end
      chk("run_low_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
      chk("run_low_count_hold", 32'(spawn_count), 32'(exp_count));
      start_run();

      while (gap > 1) frame(0, K_NORM);
      frame(0, K_KILL);
      start_run();

      while (gap > 1) frame(0, K_NORM);
      frame(0, K_RST);
      run = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("lfsr_first_after_reset", 32'(dut.lfsr), 32'(SEED));
      start_run();
      spawn_one(1);

      run = 1'b0;
      repeat (2) @(negedge clk);
      force dut.spawn_cnt_q = 16'hFFFE;
      repeat (2) @(negedge clk);
      release dut.spawn_cnt_q;
      @(negedge clk);
      chk("preload_count", 32'(spawn_count), 32'hFFFE);
      exp_count = 16'hFFFE;
      start_run();
      repeat (3) spawn_one(0);
      chk("count_saturated", 32'(spawn_count), 32'hFFFF);

      repeat (6) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
